// File: rtl/riscv_tag_pkg.sv
// Shared encodings for the DIFT tag-policy controller: instruction classes,
// TCR field positions and trap-sequencing states.
package riscv_tag_pkg;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_SHIFT  = 3'd1,
    CLS_MUL    = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5,
    CLS_JUMP   = 3'd6,
    CLS_CSR    = 3'd7
  } tag_class_e;

  localparam int TCR_EN_BIT   = 31;
  localparam int TCR_LOCK_BIT = 30;

  typedef enum logic [1:0] {
    TAG_IDLE,
    TAG_REQ,
    TAG_HANDLER
  } tag_state_e;

  // Low bit of the {d,s2,s1} enable triple for a class inside the TCR.
  function automatic logic [4:0] tcr_cls_base(input logic [2:0] cls);
    return 5'(cls) * 5'd3;
  endfunction

endpackage

// File: rtl/riscv_tag_viol_counter.sv
// Saturating violation counter; a clear in the same cycle as an increment wins.
module riscv_tag_viol_counter
  import riscv_tag_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/riscv_tag_policy_ctrl.sv
// DIFT tag-policy controller for the EX stage: TCR, per-operand check enables,
// violation capture and trap handshake. Optional TCR lock bit: TAG_POLICY_LOCK_EN.
module riscv_tag_policy_ctrl
  import riscv_tag_pkg::*;
#(
  parameter int N_CLASS   = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tcr_we_i,
  input  logic [31:0]          tcr_wdata_i,
  output logic [31:0]          tcr_o,
  input  logic [2:0]           class_i,
  input  logic                 ex_valid_i,
  output logic                 check_s1_o,
  output logic                 check_s2_o,
  output logic                 check_d_o,
  input  logic                 tag_exc_i,
  input  logic [31:0]          pc_i,
  output logic                 stall_o,
  output logic                 tag_exc_req_o,
  input  logic                 tag_exc_ack_i,
  input  logic                 trap_ret_i,
  output logic [31:0]          tag_epc_o,
  output logic [2:0]           tag_cause_o,
  output logic [CNT_WIDTH-1:0] viol_cnt_o,
  input  logic                 viol_cnt_clr_i
);

  localparam logic [31:0] CLS_MASK = 32'((64'd1 << (3 * N_CLASS)) - 64'd1);
`ifdef TAG_POLICY_LOCK_EN
  localparam logic [31:0] WR_MASK = CLS_MASK | (32'd1 << TCR_EN_BIT) | (32'd1 << TCR_LOCK_BIT);
`else
  localparam logic [31:0] WR_MASK = CLS_MASK | (32'd1 << TCR_EN_BIT);
`endif

  logic [31:0] tcr_q, tcr_d;
  tag_state_e  state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] epc_q, epc_d;
  logic [2:0]  cause_q, cause_d;
  logic        viol;
  logic [2:0]  chk_bits;

  // Reserved bits are masked on write so they always read back as zero.
  always_comb begin
    tcr_d = tcr_q;
`ifdef TAG_POLICY_LOCK_EN
    if (tcr_we_i && !tcr_q[TCR_LOCK_BIT]) begin
      tcr_d = tcr_wdata_i & WR_MASK;
    end
`else
    if (tcr_we_i) begin
      tcr_d = tcr_wdata_i & WR_MASK;
    end
`endif
  end

  always_comb begin
    chk_bits = 3'b000;
    if (state_q == TAG_IDLE && tcr_q[TCR_EN_BIT]) begin
      chk_bits = tcr_q[tcr_cls_base(class_i) +: 3];
    end
  end

  assign viol = (state_q == TAG_IDLE) & ex_valid_i & tag_exc_i;

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    unique case (state_q)
      TAG_IDLE: begin
        if (viol) begin
          state_d = TAG_REQ;
          epc_d   = pc_i;
          cause_d = class_i;
        end
      end
      TAG_REQ: begin
        if (tag_exc_ack_i) begin
          state_d = TAG_HANDLER;
        end
      end
      TAG_HANDLER: begin
        if (trap_ret_i) begin
          state_d = TAG_IDLE;
        end
      end
      default: state_d = TAG_IDLE;
    endcase
    req_d = (state_d == TAG_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcr_q   <= '0;
      state_q <= TAG_IDLE;
      req_q   <= 1'b0;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      tcr_q   <= tcr_d;
      state_q <= state_d;
      req_q   <= req_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  riscv_tag_viol_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_viol_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (viol),
    .clr_i (viol_cnt_clr_i),
    .cnt_o (viol_cnt_o)
  );

  // Stall is combinational on detection so the faulting instruction never leaves EX.
  assign stall_o       = viol | (state_q == TAG_REQ);
  assign tag_exc_req_o = req_q;
  assign tcr_o         = tcr_q;
  assign tag_epc_o     = epc_q;
  assign tag_cause_o   = cause_q;
  assign check_s1_o    = chk_bits[0];
  assign check_s2_o    = chk_bits[1];
  assign check_d_o     = chk_bits[2];

endmodule

// File: tb/tb_riscv_tag_policy_ctrl.sv
// Scoreboard bench for riscv_tag_policy_ctrl: per-cycle expectations from a
// behavioural model are queued by the stimulus and checked by a monitor.
module tb_riscv_tag_policy_ctrl;
  import riscv_tag_pkg::*;

  localparam int CW = 2;
  localparam int MAXC = (1 << CW) - 1;
`ifdef TAG_POLICY_LOCK_EN
  localparam bit LOCK = 1'b1;
  localparam logic [31:0] KEEP = 32'hC0FF_FFFF;
`else
  localparam bit LOCK = 1'b0;
  localparam logic [31:0] KEEP = 32'h80FF_FFFF;
`endif

  logic          clk, rst_n;
  logic          tcr_we;
  logic [31:0]   tcr_wdata, tcr;
  logic [2:0]    cls;
  logic          ex_valid, tag_exc, ack, trap_ret, cnt_clr;
  logic          s1, s2, d, stall, req;
  logic [31:0]   pc, epc;
  logic [2:0]    cause;
  logic [CW-1:0] cnt;

  riscv_tag_policy_ctrl #(.N_CLASS(8), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .tcr_we_i(tcr_we), .tcr_wdata_i(tcr_wdata), .tcr_o(tcr),
    .class_i(cls), .ex_valid_i(ex_valid), .check_s1_o(s1), .check_s2_o(s2), .check_d_o(d),
    .tag_exc_i(tag_exc), .pc_i(pc), .stall_o(stall), .tag_exc_req_o(req),
    .tag_exc_ack_i(ack), .trap_ret_i(trap_ret), .tag_epc_o(epc), .tag_cause_o(cause),
    .viol_cnt_o(cnt), .viol_cnt_clr_i(cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tcr;
    logic        s1, s2, d, stall, req;
    logic [31:0] epc;
    logic [2:0]  cause;
    int          cnt;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Behavioural model: trap pending / handler running flags plus architectural registers.
  logic [31:0] m_tcr, m_epc;
  logic [2:0]  m_cause;
  bit          m_pend, m_hand;
  int          m_cnt;

  task automatic model_reset();
    m_tcr = 0; m_epc = 0; m_cause = 0; m_pend = 0; m_hand = 0; m_cnt = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("tcr_o", tcr, e.tcr);
      chk("check_s1", 32'(s1), 32'(e.s1));
      chk("check_s2", 32'(s2), 32'(e.s2));
      chk("check_d", 32'(d), 32'(e.d));
      chk("stall_o", 32'(stall), 32'(e.stall));
      chk("tag_exc_req_o", 32'(req), 32'(e.req));
      chk("tag_epc_o", epc, e.epc);
      chk("tag_cause_o", 32'(cause), 32'(e.cause));
      chk("viol_cnt_o", 32'(cnt), 32'(e.cnt));
    end
  end

  task automatic cyc(input logic we, input logic [31:0] wd, input logic [2:0] c,
                     input logic exv, input logic exc, input logic [31:0] p,
                     input logic a, input logic r, input logic clr);
    exp_t e;
    bit   idle, v;
    logic [2:0] bits;
    @(posedge clk); #1;
    tcr_we = we; tcr_wdata = wd; cls = c; ex_valid = exv; tag_exc = exc;
    pc = p; ack = a; trap_ret = r; cnt_clr = clr;
    idle = !m_pend && !m_hand;
    bits = (idle && m_tcr[31]) ? 3'((m_tcr >> (3 * int'(c))) & 32'd7) : 3'd0;
    v = idle && exv && exc;
    e.tcr = m_tcr; e.s1 = bits[0]; e.s2 = bits[1]; e.d = bits[2];
    e.stall = v || m_pend; e.req = m_pend;
    e.epc = m_epc; e.cause = m_cause; e.cnt = m_cnt;
    sbq.push_back(e);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (v) begin m_epc = p; m_cause = c; end
      if (clr) m_cnt = 0;
      else if (v && m_cnt < MAXC) m_cnt++;
      if (m_pend && a) begin m_pend = 0; m_hand = 1; end
      else if (m_hand && r) m_hand = 0;
      if (v) m_pend = 1;
      if (we && !(LOCK && m_tcr[30])) m_tcr = wd & KEEP;
    end
  endtask

  task automatic idle_c(input logic [2:0] c);
    cyc(0, 0, c, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic wr(input logic [31:0] wd);
    cyc(1, wd, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic viol(input logic [31:0] p, input logic [2:0] c);
    cyc(0, 0, c, 1, 1, p, 0, 0, 0);
  endtask
  task automatic do_ack();
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask
  task automatic do_ret();
    cyc(0, 0, CLS_SHIFT, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    rst_n = 0; tcr_we = 0; tcr_wdata = 0; cls = 0; ex_valid = 0; tag_exc = 0;
    pc = 0; ack = 0; trap_ret = 0; cnt_clr = 0;
    model_reset();
    repeat (3) idle_c(CLS_SHIFT);
    @(negedge clk); rst_n = 1;

    // Check enables
    wr(32'h8000_0038);
    idle_c(CLS_SHIFT);
    idle_c(CLS_ALU);
    cyc(0, 0, CLS_SHIFT, 1, 0, 32'h40, 0, 0, 0);
    wr(32'h0000_0038);
    idle_c(CLS_SHIFT);
    wr(32'h8000_0038);

    // Violation, 3-cycle request, masked detection in handler, return
    viol(32'h0000_1A40, CLS_SHIFT);
    repeat (3) idle_c(CLS_SHIFT);
    do_ack();
    cyc(0, 0, CLS_SHIFT, 1, 1, 32'h0000_2222, 0, 0, 0);
    idle_c(CLS_SHIFT);
    do_ret();
    idle_c(CLS_SHIFT);

    // Ack in first request cycle; trap_ret / ack outside their states
    viol(32'h0000_2000, CLS_STORE);
    do_ack();
    do_ret();
    cyc(0, 0, CLS_SHIFT, 0, 0, 0, 1, 1, 0);

    // TCR write coinciding with detection uses the old TCR
    cyc(1, 32'h0, CLS_SHIFT, 1, 1, 32'h0000_3000, 0, 0, 0);
    do_ack(); do_ret();
    idle_c(CLS_SHIFT);
    wr(32'h8000_0038);

    // Saturation, then clear beating an increment, then plain clear
    repeat (2) begin viol(32'h0000_4000, CLS_MUL); do_ack(); do_ret(); end
    cyc(0, 0, CLS_JUMP, 1, 1, 32'h0000_5000, 0, 0, 1);
    do_ack(); do_ret();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    wr(32'hBF12_3456);
    idle_c(CLS_BRANCH);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 8) == 0, $urandom, 3'($urandom), 1'($urandom), ($urandom % 3) == 0,
          $urandom, ($urandom % 3) == 0, ($urandom % 4) == 0, ($urandom % 16) == 0);
    end

    // Asynchronous reset while a request is outstanding
    for (int i = 0; i < 10 && (m_pend || m_hand); i++) cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
    viol(32'h0000_6000, CLS_CSR);
    idle_c(CLS_CSR);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    model_reset();
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_tcr", tcr, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_epc", epc, 32'd0);
    idle_c(CLS_SHIFT);
    @(negedge clk); rst_n = 1;

    // Lock bit
    wr(32'hC000_0007);
    wr(32'h0);
    idle_c(CLS_ALU);
    for (int i = 0; i < 60; i++) begin
      cyc(($urandom % 4) == 0, $urandom, 3'($urandom), 1'($urandom), ($urandom % 3) == 0,
          $urandom, ($urandom % 3) == 0, ($urandom % 4) == 0, ($urandom % 16) == 0);
    end

    @(negedge clk); #1;
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
